// File: rtl/thr_store.sv
// rtl/thr_store.sv - per-neuron threshold memory with issue and write-back tracking
// Optional feature macro: THR_STORE_FWD_EN (bypass rnx into a same-neuron issue on write-back)
module thr_store #(
    parameter int          N_NEURON = 16,
    parameter int          AW       = 4,
    parameter int          LAT      = 3,
    parameter logic [15:0] R_INIT   = 16'h1200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sv,
    input  logic [AW-1:0] sidx,
    input  logic [15:0]   sdmin,
    output logic          s_rdy,
    output logic          rv,
    output logic [15:0]   rx,
    output logic [15:0]   dmin,
    input  logic          rnv,
    input  logic [15:0]   rnx,
    output logic          err
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] cnt;
    logic [15:0]   mem [N_NEURON];
    logic          tag_v   [LAT+1];
    logic [AW-1:0] tag_idx [LAT+1];
    logic          run;
    logic          hazard;
    logic          accept;
    logic          wb;
`ifdef THR_STORE_FWD_EN
    logic          bypass;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == S_INIT) begin
                cnt <= cnt + AW'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (state == S_INIT && cnt == AW'(N_NEURON - 1)) begin
            state_nx = S_RUN;
        end
    end

    // A neuron with any in-flight update must not be read until its value lands.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            if (tag_v[i] && tag_idx[i] == sidx) begin
                hazard = 1'b1;
            end
        end
`ifdef THR_STORE_FWD_EN
        bypass = 1'b0;
        if (tag_v[LAT] && tag_idx[LAT] == sidx) begin
            if (rnv) begin
                bypass = 1'b1;
            end else begin
                hazard = 1'b1;
            end
        end
`else
        if (tag_v[LAT] && tag_idx[LAT] == sidx) begin
            hazard = 1'b1;
        end
`endif
    end

    always_comb begin
        run    = (state == S_RUN);
        s_rdy  = run && !hazard;
        accept = sv && s_rdy;
        wb     = run && tag_v[LAT] && rnv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= LAT; i++) begin
                tag_v[i]   <= 1'b0;
                tag_idx[i] <= '0;
            end
        end else begin
            tag_v[0]   <= accept;
            tag_idx[0] <= sidx;
            for (int i = 1; i <= LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_INIT) begin
                mem[cnt] <= R_INIT;
            end else if (wb) begin
                mem[tag_idx[LAT]] <= rnx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rv   <= 1'b0;
            rx   <= '0;
            dmin <= '0;
        end else begin
            rv <= accept;
            if (accept) begin
`ifdef THR_STORE_FWD_EN
                rx <= bypass ? rnx : mem[sidx];
`else
                rx <= mem[sidx];
`endif
                dmin <= sdmin;
            end
        end
    end

    // Both a missing and an unexpected write-back are protocol violations.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (run && (rnv != tag_v[LAT])) begin
            err <= 1'b1;
        end
    end

endmodule

// File: doc/thr_store.md
# thr_store

Per-neuron threshold memory and issue/write-back controller on the output side of the adaptive decision-threshold unit (`decision_thr`).

- Issues each classified sample's stored threshold `rx` and its distance `dmin` to the unit.
- Writes the updated threshold `rnx` back to the same neuron.
- Tracks in-flight updates so that a neuron is never read while its update is pending.

## Interface

Parameters:
- `N_NEURON`, 16: number of stored thresholds (power of two).
- `AW`, 4: index width, log2(`N_NEURON`).
- `LAT`, 3: fixed cycles from `rv` to matching `rnv` (decision unit latency, ≥1).
- `R_INIT`, 16'h1200: threshold loaded into every neuron at reset.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `sv`, in, 1: sample valid.
- `sidx`, in, AW: winning neuron index for the sample.
- `sdmin`, in, 16: minimum distance for the sample.
- `s_rdy`, out, 1: sample accepted when `sv && s_rdy`.
- `rv`, out, 1: issue valid to decision unit.
- `rx`, out, 16: stored threshold of issued neuron.
- `dmin`, out, 16: distance forwarded with issue.
- `rnv`, in, 1: updated threshold valid from decision unit.
- `rnx`, in, 16: updated threshold.
- `err`, out, 1: sticky protocol error.

## Operation

- **INIT state** (entered on `rst`):
  - Counter sweeps addresses 0..N_NEURON-1, writing `R_INIT` to one per cycle.
  - `s_rdy` = 0 throughout.
  - After the write to N_NEURON-1, go to RUN.
- **RUN state:**
  - `s_rdy` = !hazard.
  - On accept, register `rx` = mem[`sidx`], `dmin` = `sdmin`, `rv` = 1. Otherwise `rv` = 0; `rx`/`dmin` hold.
- **Tag pipeline:** LAT+1 stages of {valid, idx}.
  - Stage 0 is loaded in the same edge as `rv`.
  - Each stage shifts every cycle.
  - Stage LAT is the entry whose `rnv` is due this cycle.
- **Write-back:** when stage LAT is valid and `rnv` = 1, mem[stage LAT idx] <= `rnx`.
- **Hazard:** `sidx` equals the idx of any valid stage 0..LAT.
  - The stage-LAT match is governed by Configuration.
- **Error:** `err` is set when either of these occurs in RUN:
  - `rnv` is high while stage LAT is invalid.
  - Stage LAT is valid while `rnv` is low. No write occurs in this case.
  - `err` is cleared only by `rst`.
- `rnv` in INIT is ignored and does not set `err`.
- Distinct neurons stream at one sample per cycle.
- **Write/read collision:** a memory write and an accept to different addresses in the same cycle both proceed.

## Timing

- **Reset values:**
  - `rv` = 0, `rx` = 0, `dmin` = 0, `err` = 0, `s_rdy` = 0.
  - All tag valids = 0.
  - State = INIT, counter = 0.
- **INIT duration:** N_NEURON cycles after `rst` deasserts. `s_rdy` can first be 1 on cycle N_NEURON+1 (cycle 1 = first cycle with `rst` low).
- **Issue latency:** 1 cycle, accept at edge t gives `rv`/`rx`/`dmin` valid after edge t.
- **Write-back window:** `rnv` is required exactly LAT cycles after the cycle `rv` was high.
- **Written value visibility:** readable by an accept in the next cycle.
- **Reset mid-operation:**
  - Tags are flushed.
  - Any pending updates are discarded.
  - The memory is reinitialised by a full INIT sweep.
- **`s_rdy` timing:** combinational from `sidx` and the tag state. The upstream side holds `sv`/`sidx`/`sdmin` stable while `s_rdy` = 0.

## Configuration

- Macro: `THR_STORE_FWD_EN`.
- **Defined:**
  - A match only against stage LAT, with `rnv` = 1, is not a hazard.
  - The sample is accepted and `rx` is loaded from `rnx` (bypass).
  - A same-neuron sample stalls LAT cycles.
- **Undefined:**
  - Stage LAT is included in the hazard.
  - The sample is accepted the cycle after write-back.
  - A same-neuron sample stalls LAT+1 cycles.

## Test plan

- **Reset/INIT:**
  - Stimulus: `rst` for 2 cycles; then `sv` = 1 for idx 0..15 with `rnv` looped back.
  - Expected: `s_rdy` low 16 cycles, then every `rx` = 16'h1200.
- **Single update (LAT = 3):**
  - Stimulus: issue idx 5; drive `rnv` with `rnx` = 16'h1300 3 cycles after `rv`; then issue idx 5 again.
  - Expected: `rx` = 16'h1300.
- **Throughput:**
  - Stimulus: idx 0..15 back-to-back with `sdmin` = idx×16'h64, model decision unit returning `rx`+1 at LAT.
  - Expected: 16 consecutive `rv` cycles, `dmin` matches, second pass reads 16'h1201, `err` = 0.
- **Hazard:**
  - Stimulus: idx 7 followed immediately by idx 7.
  - Expected without `THR_STORE_FWD_EN`: second `rv` exactly 5 cycles after the first.
  - Expected with `THR_STORE_FWD_EN`: 4 cycles, `rx` equal to the bypassed `rnx`.
- **Protocol error:**
  - Stimulus: suppress `rnv` for one issued sample.
  - Expected: `err` = 1 at cycle `rv`+LAT+1 and held; memory unchanged.
  - Stimulus: a spurious `rnv` with no issue.
  - Expected: also sets `err`.
- **Mid-operation reset:**
  - Stimulus: assert `rst` while 3 updates are in flight, with `rnv` still arriving.
  - Expected: no writes, re-INIT, all `rx` = 16'h1200, `err` = 0.
